// File: rtl/trdb_pkg.sv
// Shared packet format/subformat types for the trace encoder.
// Encodings follow the trace packet header fields.
package trdb_pkg;

    typedef enum logic [1:0] {
        F_BRANCH_DIFF = 2'h0,
        F_BRANCH_FULL = 2'h1,
        F_ADDR_ONLY   = 2'h2,
        F_SYNC        = 2'h3
    } trdb_format_t;

    typedef enum logic [1:0] {
        SF_START     = 2'h0,
        SF_EXCEPTION = 2'h1,
        SF_CONTEXT   = 2'h2,
        SF_UNDEF     = 2'h3
    } trdb_subformat_t;

endpackage

// File: rtl/trdb_resync_cnt.sv
// Counts accepted instructions since the last sync packet and raises
// a sticky resync request once the threshold is reached.
module trdb_resync_cnt #(
    parameter int unsigned RESYNC_MAX = 256
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic tick_i,
    input  logic clear_i,
    output logic pend_o
);

    localparam int unsigned W = $clog2(RESYNC_MAX);
    localparam logic [W-1:0] LAST = W'(RESYNC_MAX - 1);

    logic [W-1:0] r_cnt;
    logic         r_pend;
    logic [W-1:0] w_next;

    assign w_next = r_cnt + 1'b1;
    assign pend_o = r_pend;

    // Saturates at LAST: once pending, further ticks are ignored
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt  <= '0;
            r_pend <= 1'b0;
        end else if (clear_i) begin
            r_cnt  <= '0;
            r_pend <= 1'b0;
        end else if (tick_i && !r_pend) begin
            r_cnt <= w_next;
            if (w_next == LAST) begin
                r_pend <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/trdb_priority_seq.sv
// Registered packet-priority decoder with resync, exception-sync
// suppression, branch-map full detection and valid/ready output.
module trdb_priority_seq
    import trdb_pkg::*;
#(
    parameter int unsigned BRANCH_MAP_LEN = 31,
    parameter int unsigned RESYNC_MAX     = 256,
    localparam int unsigned CNT_W         = $clog2(BRANCH_MAP_LEN + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    input  logic            lc_exception_i,
    input  logic            tc_first_qualified_i,
    input  logic            tc_unhalted_i,
    input  logic            tc_privchange_i,
    input  logic            tc_context_change_i,
    input  logic            lc_u_discontinuity_i,
    input  logic            nc_halt_i,
    input  logic            nc_exception_i,
    input  logic            nc_privchange_i,
    input  logic            nc_unqualified_i,
    input  logic [CNT_W-1:0] branch_map_cnt_i,
    input  logic            ready_i,
    output logic            valid_o,
    output trdb_format_t    packet_format_o,
    output trdb_subformat_t packet_subformat_o,
    output logic            stall_o,
    output logic            overflow_o
);

    logic            r_valid;
    trdb_format_t    r_fmt;
    trdb_subformat_t r_sf;
    logic            r_ovf;
    logic            r_ex_sync;

    logic            w_stall;
    logic            w_accept;
    logic            w_map;
    logic            w_full;
    logic            w_start;
    logic            w_nc;
    logic            w_pend;
    logic            w_emit;
    logic            w_sync;
    trdb_format_t    w_fmt;
    trdb_subformat_t w_sf;

    assign w_stall  = r_valid & ~ready_i;
    assign w_accept = valid_i & ~w_stall;
    assign w_map    = (branch_map_cnt_i != '0);
    assign w_full   = (branch_map_cnt_i == CNT_W'(BRANCH_MAP_LEN));
    assign w_start  = (tc_first_qualified_i | tc_unhalted_i | tc_privchange_i)
                    & ~r_ex_sync;
    assign w_nc     = nc_halt_i | nc_exception_i
                    | nc_privchange_i | nc_unqualified_i;
    assign w_sync   = w_emit & (w_fmt == F_SYNC);

    always_comb begin
        w_emit = 1'b0;
        w_fmt  = F_ADDR_ONLY;
        w_sf   = SF_UNDEF;
        priority case (1'b1)
            lc_exception_i: begin
                w_emit = 1'b1;
                w_fmt  = F_SYNC;
                w_sf   = SF_EXCEPTION;
            end
            w_start: begin
                w_emit = 1'b1;
                w_fmt  = F_SYNC;
                w_sf   = SF_START;
            end
            lc_u_discontinuity_i: begin
                w_emit = 1'b1;
                w_fmt  = w_map ? F_BRANCH_FULL : F_ADDR_ONLY;
            end
            // With branches queued, flush them first and keep the resync pending
            w_pend: begin
                w_emit = 1'b1;
                w_fmt  = w_map ? F_BRANCH_FULL : F_SYNC;
                w_sf   = w_map ? SF_UNDEF : SF_START;
            end
            w_nc: begin
                w_emit = 1'b1;
                w_fmt  = w_map ? F_BRANCH_FULL : F_ADDR_ONLY;
            end
            w_full: begin
                w_emit = 1'b1;
                w_fmt  = F_BRANCH_FULL;
            end
            tc_context_change_i: begin
                w_emit = 1'b1;
                w_fmt  = F_SYNC;
                w_sf   = SF_CONTEXT;
            end
            default: begin
                w_emit = 1'b0;
            end
        endcase
    end

    trdb_resync_cnt #(
        .RESYNC_MAX(RESYNC_MAX)
    ) u_resync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .tick_i (w_accept),
        .clear_i(w_accept & w_sync),
        .pend_o (w_pend)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ex_sync <= 1'b0;
        end else if (w_accept) begin
            r_ex_sync <= lc_exception_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_fmt   <= F_ADDR_ONLY;
            r_sf    <= SF_UNDEF;
            r_ovf   <= 1'b0;
        end else begin
            if (valid_i && w_stall) begin
                r_ovf <= 1'b1;
            end
            if (w_accept && w_emit) begin
                r_valid <= 1'b1;
                r_fmt   <= w_fmt;
                r_sf    <= w_sf;
            end else if (ready_i) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign valid_o            = r_valid;
    assign packet_format_o    = r_fmt;
    assign packet_subformat_o = r_sf;
    assign stall_o            = w_stall;
    assign overflow_o         = r_ovf;

endmodule

// File: tb/tb_trdb_priority_seq.sv
// Testbench for trdb_priority_seq: vector table with a scoreboard queue
// plus hand-written stall/overflow and reset-during-stall sequences.
module tb_trdb_priority_seq;
    import trdb_pkg::*;

    logic            clk = 1'b0;
    logic            rst_i;
    logic            valid_i;
    logic            lc_exception_i;
    logic            tc_first_qualified_i;
    logic            tc_unhalted_i;
    logic            tc_privchange_i;
    logic            tc_context_change_i;
    logic            lc_u_discontinuity_i;
    logic            nc_halt_i;
    logic            nc_exception_i;
    logic            nc_privchange_i;
    logic            nc_unqualified_i;
    logic [4:0]      branch_map_cnt_i;
    logic            ready_i;
    logic            valid_o;
    trdb_format_t    packet_format_o;
    trdb_subformat_t packet_subformat_o;
    logic            stall_o;
    logic            overflow_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    trdb_priority_seq #(
        .BRANCH_MAP_LEN(31),
        .RESYNC_MAX    (4)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst_i),
        .valid_i             (valid_i),
        .lc_exception_i      (lc_exception_i),
        .tc_first_qualified_i(tc_first_qualified_i),
        .tc_unhalted_i       (tc_unhalted_i),
        .tc_privchange_i     (tc_privchange_i),
        .tc_context_change_i (tc_context_change_i),
        .lc_u_discontinuity_i(lc_u_discontinuity_i),
        .nc_halt_i           (nc_halt_i),
        .nc_exception_i      (nc_exception_i),
        .nc_privchange_i     (nc_privchange_i),
        .nc_unqualified_i    (nc_unqualified_i),
        .branch_map_cnt_i    (branch_map_cnt_i),
        .ready_i             (ready_i),
        .valid_o             (valid_o),
        .packet_format_o     (packet_format_o),
        .packet_subformat_o  (packet_subformat_o),
        .stall_o             (stall_o),
        .overflow_o          (overflow_o)
    );

    typedef struct {
        bit              rst;
        bit              v;
        bit              lce;
        bit              fq;
        bit              uh;
        bit              pc;
        bit              ctx;
        bit              lcu;
        logic [3:0]      nc;
        logic [4:0]      bm;
        bit              ev;
        trdb_format_t    ef;
        trdb_subformat_t es;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    function automatic vec_t mk(bit rst, bit v, bit lce, bit fq, bit uh,
                                bit pc, bit ctx, bit lcu, logic [3:0] nc,
                                logic [4:0] bm, bit ev, trdb_format_t ef,
                                trdb_subformat_t es);
        vec_t r;
        r.rst = rst; r.v = v; r.lce = lce; r.fq = fq; r.uh = uh;
        r.pc = pc; r.ctx = ctx; r.lcu = lcu; r.nc = nc; r.bm = bm;
        r.ev = ev; r.ef = ef; r.es = es;
        return r;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        valid_i = 0; lc_exception_i = 0; tc_first_qualified_i = 0;
        tc_unhalted_i = 0; tc_privchange_i = 0; tc_context_change_i = 0;
        lc_u_discontinuity_i = 0; nc_halt_i = 0; nc_exception_i = 0;
        nc_privchange_i = 0; nc_unqualified_i = 0; branch_map_cnt_i = '0;
    endtask

    task automatic drive(vec_t r);
        valid_i              = r.v;
        lc_exception_i       = r.lce;
        tc_first_qualified_i = r.fq;
        tc_unhalted_i        = r.uh;
        tc_privchange_i      = r.pc;
        tc_context_change_i  = r.ctx;
        lc_u_discontinuity_i = r.lcu;
        nc_halt_i            = r.nc[0];
        nc_exception_i       = r.nc[1];
        nc_privchange_i      = r.nc[2];
        nc_unqualified_i     = r.nc[3];
        branch_map_cnt_i     = r.bm;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_i = 1;
        @(posedge clk); #1;
        rst_i = 0;
    endtask

    task automatic step();
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic chk_pkt(string name, bit ev, trdb_format_t ef,
                           trdb_subformat_t es);
        chk({name, " valid"}, int'(valid_o), int'(ev));
        if (ev) begin
            chk({name, " fmt"}, int'(packet_format_o), int'(ef));
            chk({name, " sf"}, int'(packet_subformat_o), int'(es));
        end
    endtask

    initial begin
        vec_t r;
        idle_inputs();
        ready_i = 1;
        rst_i = 1;
        repeat (2) @(posedge clk);
        #1;
        rst_i = 0;
        chk("reset valid", int'(valid_o), 0);
        chk("reset fmt", int'(packet_format_o), int'(F_ADDR_ONLY));
        chk("reset sf", int'(packet_subformat_o), int'(SF_UNDEF));
        chk("reset ovf", int'(overflow_o), 0);
        chk("reset stall", int'(stall_o), 0);

        // rst v lce fq uh pc ctx lcu nc bm | ev fmt sf
        tbl.push_back(mk(1,1,0,1,0,0,0,0,4'h0, 0, 1,F_SYNC,SF_START));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,4'h0, 0, 0,F_ADDR_ONLY,SF_UNDEF));
        tbl.push_back(mk(1,1,1,0,0,0,0,0,4'h0, 0, 1,F_SYNC,SF_EXCEPTION));
        tbl.push_back(mk(0,1,0,0,0,1,0,0,4'h0, 0, 0,F_ADDR_ONLY,SF_UNDEF));
        tbl.push_back(mk(0,1,0,0,0,1,0,0,4'h0, 0, 1,F_SYNC,SF_START));
        tbl.push_back(mk(1,1,0,0,0,0,0,0,4'h0, 0, 0,F_ADDR_ONLY,SF_UNDEF));
        tbl.push_back(mk(0,1,0,0,0,0,0,0,4'h0, 0, 0,F_ADDR_ONLY,SF_UNDEF));
        tbl.push_back(mk(0,1,0,0,0,0,0,0,4'h0, 0, 0,F_ADDR_ONLY,SF_UNDEF));
        tbl.push_back(mk(0,1,0,0,0,0,0,0,4'h0, 0, 1,F_SYNC,SF_START));
        tbl.push_back(mk(1,1,0,0,0,0,0,0,4'h0, 5, 0,F_ADDR_ONLY,SF_UNDEF));
        tbl.push_back(mk(0,1,0,0,0,0,0,0,4'h0, 5, 0,F_ADDR_ONLY,SF_UNDEF));
        tbl.push_back(mk(0,1,0,0,0,0,0,0,4'h0, 5, 0,F_ADDR_ONLY,SF_UNDEF));
        tbl.push_back(mk(0,1,0,0,0,0,0,0,4'h0, 5, 1,F_BRANCH_FULL,SF_UNDEF));
        tbl.push_back(mk(0,1,0,0,0,0,0,0,4'h0, 0, 1,F_SYNC,SF_START));
        tbl.push_back(mk(1,1,0,0,0,0,0,1,4'h0, 0, 1,F_ADDR_ONLY,SF_UNDEF));
        tbl.push_back(mk(0,1,0,0,0,0,0,1,4'h0, 3, 1,F_BRANCH_FULL,SF_UNDEF));
        tbl.push_back(mk(0,1,0,0,0,0,0,0,4'h0,31, 1,F_BRANCH_FULL,SF_UNDEF));
        tbl.push_back(mk(1,1,0,0,0,0,1,0,4'h0, 0, 1,F_SYNC,SF_CONTEXT));
        tbl.push_back(mk(0,1,0,0,0,0,0,0,4'h1, 0, 1,F_ADDR_ONLY,SF_UNDEF));
        tbl.push_back(mk(0,1,0,0,0,0,0,0,4'h8, 2, 1,F_BRANCH_FULL,SF_UNDEF));
        tbl.push_back(mk(0,1,0,1,0,0,0,1,4'h0, 0, 1,F_SYNC,SF_START));
        tbl.push_back(mk(0,1,1,1,0,0,0,0,4'h0, 0, 1,F_SYNC,SF_EXCEPTION));
        tbl.push_back(mk(0,1,0,0,1,0,1,0,4'h0, 0, 1,F_SYNC,SF_CONTEXT));
        tbl.push_back(mk(0,1,0,0,0,0,1,0,4'h2, 0, 1,F_ADDR_ONLY,SF_UNDEF));
        tbl.push_back(mk(0,1,0,0,0,0,1,0,4'h0,31, 1,F_BRANCH_FULL,SF_UNDEF));
        tbl.push_back(mk(0,1,0,0,0,0,0,0,4'h0, 0, 0,F_ADDR_ONLY,SF_UNDEF));
        tbl.push_back(mk(0,1,0,0,0,0,0,0,4'h4, 0, 1,F_SYNC,SF_START));

        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            drive(tbl[i]);
            sb.push_back(tbl[i]);
            step();
            r = sb.pop_front();
            chk_pkt($sformatf("row%0d", i), r.ev, r.ef, r.es);
        end

        // Hold under backpressure, overflow on dropped inputs
        do_reset();
        ready_i = 0;
        tc_first_qualified_i = 1;
        valid_i = 1;
        step();
        for (int k = 0; k < 3; k++) begin
            chk_pkt($sformatf("hold%0d", k), 1, F_SYNC, SF_START);
            chk($sformatf("hold%0d stall", k), int'(stall_o), 1);
            if (k == 1) begin
                valid_i = 1;
                lc_exception_i = 1;
            end
            step();
        end
        chk("ovf set", int'(overflow_o), 1);
        chk_pkt("hold kept", 1, F_SYNC, SF_START);
        valid_i = 1;
        step();
        ready_i = 1;
        step();
        chk("drain valid", int'(valid_o), 0);
        chk("ovf sticky", int'(overflow_o), 1);
        for (int k = 0; k < 3; k++) begin
            valid_i = 1;
            step();
            chk($sformatf("post%0d valid", k), int'(valid_o), 0);
        end
        valid_i = 1;
        step();
        chk_pkt("post resync", 1, F_SYNC, SF_START);
        step();

        // Reset drops a held packet
        ready_i = 0;
        valid_i = 1;
        tc_context_change_i = 1;
        step();
        chk_pkt("pre-rst", 1, F_SYNC, SF_CONTEXT);
        chk("pre-rst ovf", int'(overflow_o), 1);
        do_reset();
        chk("rst valid", int'(valid_o), 0);
        chk("rst fmt", int'(packet_format_o), int'(F_ADDR_ONLY));
        chk("rst sf", int'(packet_subformat_o), int'(SF_UNDEF));
        chk("rst ovf", int'(overflow_o), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
